obi_rr_arbiter: RTL and testbench



---
 rtl/obi_arb_pkg.sv | 50 +++++
 rtl/obi_arb_id_fifo.sv | 67 ++++++
 rtl/obi_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_obi_rr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types, default parameters and width helpers for the OBI round-robin arbiter.
// Optional build macro OBI_ARB_FIXED_PRIO_EN is consumed by obi_rr_arbiter.
package obi_arb_pkg;

    localparam int unsigned DefaultNumMgr   = 2;
    localparam int unsigned DefaultMaxTrans = 4;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = DataW / 8;

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a counter that must hold 0..d inclusive.
    function automatic int unsigned cnt_width(input int unsigned d);
        int unsigned w;
        w = $clog2(d + 1);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic             we;
        logic [BeW-1:0]   be;
        logic [DataW-1:0] wdata;
    } obi_a_t;

    typedef struct packed {
        logic [DataW-1:0] rdata;
        logic             err;
    } obi_r_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
        logic   rready;
    } obi_arb_req_t;

    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } obi_arb_rsp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted manager indices; head selects the response destination.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned Depth = DefaultMaxTrans,
    parameter int unsigned Width = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [Width-1:0]             wdata,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [Width-1:0]             head,
    output logic [cnt_width(Depth)-1:0]  count
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Shares one OBI subordinate among NumMgr managers with round-robin address arbitration.
// Define OBI_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NumMgr   = DefaultNumMgr,
    parameter int unsigned MaxTrans = DefaultMaxTrans,
    parameter type         obi_req_t = obi_arb_req_t,
    parameter type         obi_rsp_t = obi_arb_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_ports_req_i [NumMgr],
    output obi_rsp_t sbr_ports_rsp_o [NumMgr],
    output obi_req_t mgr_port_req_o,
    input  obi_rsp_t mgr_port_rsp_i,
    output logic     busy_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);
    localparam int unsigned CntW = cnt_width(MaxTrans);

    logic [IdxW-1:0] sel_q;
    logic            lock_q;
    logic [IdxW-1:0] arb_winner;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] winner_inc;
    logic            mgr_req;
    logic            handshake;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] fifo_head;
    logic [CntW-1:0] fifo_count;

`ifdef OBI_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins.
    always_comb begin
        arb_winner = '0;
        for (int i = NumMgr - 1; i >= 0; i--) begin
            if (sbr_ports_req_i[i].req) begin
                arb_winner = IdxW'(i);
            end
        end
    end
`else
    logic [IdxW-1:0] rr_ptr_q;
    int unsigned     cand;
    logic            found;

    // First requester at or after rr_ptr_q, wrapping past NumMgr-1.
    always_comb begin
        arb_winner = rr_ptr_q;
        found      = 1'b0;
        cand       = 0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NumMgr) begin
                cand = cand - NumMgr;
            end
            if (!found && sbr_ports_req_i[cand].req) begin
                arb_winner = IdxW'(cand);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= winner_inc;
        end
    end
`endif

    assign winner     = lock_q ? sel_q : arb_winner;
    assign winner_inc = (winner == IdxW'(NumMgr - 1)) ? '0 : winner + IdxW'(1);
    assign mgr_req    = sbr_ports_req_i[winner].req & ~fifo_full;
    assign handshake  = mgr_req & mgr_port_rsp_i.gnt;
    assign fifo_pop   = mgr_port_rsp_i.rvalid & mgr_port_req_o.rready & ~fifo_empty;
    assign busy_o     = (fifo_count != '0);

    // Hold the selection while a forwarded request waits for its grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else if (handshake) begin
            lock_q <= 1'b0;
        end else if (mgr_req) begin
            lock_q <= 1'b1;
            sel_q  <= winner;
        end
    end

    always_comb begin
        mgr_port_req_o        = sbr_ports_req_i[winner];
        mgr_port_req_o.req    = mgr_req;
        mgr_port_req_o.rready = sbr_ports_req_i[fifo_head].rready;
    end

    // Grant goes to the winner only; rvalid only to the oldest outstanding owner.
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            sbr_ports_rsp_o[i]        = '0;
            sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
            sbr_ports_rsp_o[i].gnt    = (IdxW'(i) == winner) & handshake;
            sbr_ports_rsp_o[i].rvalid = (IdxW'(i) == fifo_head) & ~fifo_empty
                                        & mgr_port_rsp_i.rvalid;
        end
    end

    obi_arb_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (handshake),
        .wdata (winner),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed self-checking bench for obi_rr_arbiter with NumMgr=2, MaxTrans=4.
module tb_obi_rr_arbiter;
    import obi_arb_pkg::*;

`ifdef OBI_ARB_FIXED_PRIO_EN
    localparam logic [1:0] ALT1 = 2'b01;
`else
    localparam logic [1:0] ALT1 = 2'b10;
`endif

    logic         clk;
    logic         rst_n;
    obi_arb_req_t req_s [2];
    obi_arb_rsp_t rsp_s [2];
    obi_arb_req_t mreq;
    obi_arb_rsp_t mrsp;
    logic         busy;
    logic [1:0]   gnt_v;
    logic [1:0]   rv_v;

    int checks;
    int failures;

    obi_rr_arbiter #(
        .NumMgr   (2),
        .MaxTrans (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .sbr_ports_req_i (req_s),
        .sbr_ports_rsp_o (rsp_s),
        .mgr_port_req_o  (mreq),
        .mgr_port_rsp_i  (mrsp),
        .busy_o          (busy)
    );

    assign gnt_v = {rsp_s[1].gnt, rsp_s[0].gnt};
    assign rv_v  = {rsp_s[1].rvalid, rsp_s[0].rvalid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) req_s[i] = '0;
        mrsp = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clr();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt_v), 0);
        chk("rst_rvalid", 32'(rv_v), 0);
        chk("rst_mreq", 32'(mreq.req), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both managers request continuously with gnt tied high.
        req_s[0].req = 1'b1; req_s[0].a.addr = 32'h100; req_s[0].rready = 1'b1;
        req_s[1].req = 1'b1; req_s[1].a.addr = 32'h200; req_s[1].rready = 1'b1;
        mrsp.gnt = 1'b1;
        #2; chk("alt_g0", 32'(gnt_v), 32'(2'b01)); chk("alt_a0", mreq.a.addr, 32'h100);
        tick();
        #2; chk("alt_g1", 32'(gnt_v), 32'(ALT1));
        tick();
        #2; chk("alt_g2", 32'(gnt_v), 32'(2'b01));
        tick();
        #2; chk("alt_g3", 32'(gnt_v), 32'(ALT1));
        tick();
        req_s[0].req = 1'b0; req_s[1].req = 1'b0; mrsp.gnt = 1'b0;
        mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hD0;
        #2; chk("alt_r0", 32'(rv_v), 32'(2'b01)); chk("alt_d0", rsp_s[0].r.rdata, 32'hD0);
        tick();
        mrsp.r.rdata = 32'hD1;
        #2; chk("alt_r1", 32'(rv_v), 32'(ALT1)); chk("alt_d1", rsp_s[1].r.rdata, 32'hD1);
        tick();
        #2; chk("alt_r2", 32'(rv_v), 32'(2'b01));
        tick();
        #2; chk("alt_r3", 32'(rv_v), 32'(ALT1));
        tick();
        mrsp.rvalid = 1'b0;
        #2; chk("alt_idle", 32'(busy), 0);
        tick();

        // Manager 1 waits for grant; manager 0 arrives later and must not steal it.
        req_s[1].req = 1'b1; req_s[1].a.addr = 32'h220;
        #2; chk("lk_mreq", 32'(mreq.req), 1); chk("lk_a1", mreq.a.addr, 32'h220);
        chk("lk_g1", 32'(gnt_v), 0);
        tick();
        req_s[0].req = 1'b1; req_s[0].a.addr = 32'h110;
        #2; chk("lk_a2", mreq.a.addr, 32'h220); chk("lk_g2", 32'(gnt_v), 0);
        tick();
        #2; chk("lk_a3", mreq.a.addr, 32'h220);
        tick();
        mrsp.gnt = 1'b1;
        #2; chk("lk_g4", 32'(gnt_v), 32'(2'b10)); chk("lk_a4", mreq.a.addr, 32'h220);
        tick();
        req_s[1].req = 1'b0;
        #2; chk("lk_g5", 32'(gnt_v), 32'(2'b01)); chk("lk_a5", mreq.a.addr, 32'h110);
        tick();
        req_s[0].req = 1'b0; mrsp.gnt = 1'b0;
        #2; chk("lk_busy", 32'(busy), 1);
        mrsp.rvalid = 1'b1;
        #1; chk("lk_r0", 32'(rv_v), 32'(2'b10));
        tick();
        #2; chk("lk_r1", 32'(rv_v), 32'(2'b01));
        tick();
        mrsp.rvalid = 1'b0;

        // Fill the ID FIFO and verify the request is held off until a pop.
        req_s[0].req = 1'b1; mrsp.gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_s[0].a.addr = 32'h300 + 32'(k);
            #2; chk("full_fill", 32'(gnt_v), 32'(2'b01));
            tick();
        end
        req_s[0].a.addr = 32'h380;
        #2; chk("full_mreq", 32'(mreq.req), 0); chk("full_gnt", 32'(gnt_v), 0);
        chk("full_busy", 32'(busy), 1);
        tick();
        mrsp.rvalid = 1'b1;
        #2; chk("full_nobyp", 32'(gnt_v), 0); chk("full_rv", 32'(rv_v), 32'(2'b01));
        tick();
        mrsp.rvalid = 1'b0;
        #2; chk("full_g5", 32'(gnt_v), 32'(2'b01)); chk("full_mreq5", 32'(mreq.req), 1);
        tick();
        req_s[0].req = 1'b0; mrsp.gnt = 1'b0;

        // Manager 0 stalls its response; nothing may pop and port 1 stays quiet.
        req_s[0].rready = 1'b0;
        mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hAAAA;
        #2; chk("hold_rv", 32'(rv_v), 32'(2'b01)); chk("hold_rr", 32'(mreq.rready), 0);
        chk("hold_d", rsp_s[0].r.rdata, 32'hAAAA);
        tick();
        #2; chk("hold_rv2", 32'(rv_v), 32'(2'b01));
        tick();
        req_s[0].rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2; chk("hold_drain", 32'(rv_v), 32'(2'b01));
            tick();
        end
        mrsp.rvalid = 1'b0;
        #2; chk("hold_empty", 32'(busy), 0);
        tick();

        // Reset with two outstanding transactions discards them.
        req_s[0].req = 1'b1; req_s[1].req = 1'b1; mrsp.gnt = 1'b1;
        #2; chk("rs_g0", 32'(gnt_v), 32'(ALT1));
        tick();
        #2; chk("rs_g1", 32'(gnt_v), 32'(2'b01));
        tick();
        req_s[0].req = 1'b0; req_s[1].req = 1'b0; mrsp.gnt = 1'b0;
        #2; chk("rs_busy1", 32'(busy), 1);
        rst_n = 1'b0;
        #1; chk("rs_busy0", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        mrsp.rvalid = 1'b1;
        #2; chk("rs_stray", 32'(rv_v), 0); chk("rs_idle", 32'(busy), 0);
        tick();
        mrsp.rvalid = 1'b0;
        req_s[0].req = 1'b1; req_s[1].req = 1'b1; mrsp.gnt = 1'b1;
        #2; chk("rs_ptr", 32'(gnt_v), 32'(2'b01));
        tick();
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
